// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default
// frame parameters and oversampling constants.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // 16 s_ticks per bit; mid-bit sample lands on tick index 7
  localparam int OVS     = 16;
  localparam int OVS_MID = OVS / 2 - 1;

  // Tick counter width: must reach max_cnt-1 and never be narrower than
  // the 4 bits needed for one oversampled bit period.
  function automatic int cnt_width(input int max_cnt);
    int w;
    w = $clog2(max_cnt);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and tick in, parallel word,
// completion pulse and status out.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;
  logic [1:0]      state_out;

  // Line/tick source side
  modport master (
    output rx, s_tick,
    input  rx_dout, rx_done_tick, frame_err, busy, state_out
  );

  // Receiver side
  modport slave (
    input  rx, s_tick,
    output rx_dout, rx_done_tick, frame_err, busy, state_out
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset level so idle-high lines come out of reset inactive.
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the async input, then re-register to settle metastability
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start-bit qualified at mid-bit, DBIT data
// bits LSB first, stop bit checked at its centre. Delivers the word with a
// one-clock done pulse and a framing-error flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int SW = cnt_width(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVS_MID);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  uart_state_t     state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] dout;
  logic            done;
  logic            ferr;
  logic            rx_s;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start
  uart_rx_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Frame FSM: start detection, tick counting, bit shifting and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      dout  <= '0;
      done  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Falling edge arms the receiver at once; ticks are not needed here
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        // Re-check the line at mid start bit to reject short glitches
        START: begin
          if (bus.s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        // One full bit period per sample keeps each sample at mid-bit
        DATA: begin
          if (bus.s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        // Data is delivered even with a low stop bit; the flag reports it
        STOP: begin
          if (bus.s_tick) begin
            if (s == S_STOP) begin
              dout  <= b;
              ferr  <= ~rx_s;
              done  <= 1'b1;
              state <= IDLE;
              s     <= '0;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.rx_dout      = dout;
  assign bus.rx_done_tick = done;
  assign bus.frame_err    = ferr;
  assign bus.busy         = (state != IDLE);
  assign bus.state_out    = state;

endmodule
